// File: rtl/td_cpu.sv
// td_cpu: parametrised TD4-class core; a fetch/execute FSM runs one instruction per tick from a synchronous ROM.
// Optional macro TD_CPU_HALT_EN turns opcode 1100 into HALT (absorbing HALTED state). ADDR_W must not exceed DATA_W.
module td_cpu #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W+3:0] rom_data,
    input  logic [DATA_W-1:0] user_in,
    output logic [DATA_W-1:0] user_out,
    output logic              carry,
    output logic              retire,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_EXEC   = 2'b01
`ifdef TD_CPU_HALT_EN
        , ST_HALTED = 2'b10
`endif
    } state_t;

    state_t            state_r, state_nx;
    logic [ADDR_W-1:0] pc_r, pc_nx, pc_inc_s;
    logic [DATA_W-1:0] a_r, a_nx, b_r, b_nx, out_r, out_nx;
    logic              carry_r, carry_nx, retire_r, retire_nx;
    logic [3:0]        opcode_s;
    logic [DATA_W-1:0] imm_s;

    // Carry-out lands in the extra top bit of the result.
    function automatic logic [DATA_W:0] add_im(input logic [DATA_W-1:0] r, input logic [DATA_W-1:0] im);
        return {1'b0, r} + {1'b0, im};
    endfunction

    assign opcode_s = rom_data[DATA_W+3:DATA_W];
    assign imm_s    = rom_data[DATA_W-1:0];
    assign pc_inc_s = pc_r + ADDR_W'(1);

`ifdef TD_CPU_HALT_EN
    logic halted_r, halted_nx;
`endif

    // Next-state decode: FETCH waits for tick, EXEC commits one instruction.
    always_comb begin
        state_nx  = state_r;
        pc_nx     = pc_r;
        a_nx      = a_r;
        b_nx      = b_r;
        out_nx    = out_r;
        carry_nx  = carry_r;
        retire_nx = 1'b0;
`ifdef TD_CPU_HALT_EN
        halted_nx = halted_r;
`endif
        case (state_r)
            ST_FETCH: begin
                if (tick) begin
                    state_nx = ST_EXEC;
                end else begin
                    state_nx = ST_FETCH;
                end
            end
            ST_EXEC: begin
                state_nx  = ST_FETCH;
                retire_nx = 1'b1;
                carry_nx  = 1'b0;
                pc_nx     = pc_inc_s;
                case (opcode_s)
                    4'b0000: {carry_nx, a_nx} = add_im(a_r, imm_s);
                    4'b0001: a_nx = b_r;
                    4'b0010: a_nx = user_in;
                    4'b0011: a_nx = imm_s;
                    4'b0100: b_nx = a_r;
                    4'b0101: {carry_nx, b_nx} = add_im(b_r, imm_s);
                    4'b0110: b_nx = user_in;
                    4'b0111: b_nx = imm_s;
                    4'b1001: out_nx = b_r;
                    4'b1011: out_nx = imm_s;
                    // JNC looks at the carry left by the previous instruction.
                    4'b1110: begin
                        if (!carry_r) begin
                            pc_nx = imm_s[ADDR_W-1:0];
                        end else begin
                            pc_nx = pc_inc_s;
                        end
                    end
                    4'b1111: pc_nx = imm_s[ADDR_W-1:0];
`ifdef TD_CPU_HALT_EN
                    4'b1100: begin
                        state_nx  = ST_HALTED;
                        pc_nx     = pc_r;
                        halted_nx = 1'b1;
                    end
`endif
                    default: pc_nx = pc_inc_s;
                endcase
            end
`ifdef TD_CPU_HALT_EN
            ST_HALTED: state_nx = ST_HALTED;
`endif
            default: state_nx = ST_FETCH;
        endcase
    end

    // State and architectural registers; reset discards any in-flight EXEC.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r  <= ST_FETCH;
            pc_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            out_r    <= '0;
            carry_r  <= 1'b0;
            retire_r <= 1'b0;
`ifdef TD_CPU_HALT_EN
            halted_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_nx;
            pc_r     <= pc_nx;
            a_r      <= a_nx;
            b_r      <= b_nx;
            out_r    <= out_nx;
            carry_r  <= carry_nx;
            retire_r <= retire_nx;
`ifdef TD_CPU_HALT_EN
            halted_r <= halted_nx;
`endif
        end
    end

    assign rom_addr = pc_r;
    assign user_out = out_r;
    assign carry    = carry_r;
    assign retire   = retire_r;
`ifdef TD_CPU_HALT_EN
    assign halted   = halted_r;
`else
    assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_td_cpu.sv
// Scoreboard bench for td_cpu: two instances (4/4 and 8/6 widths) checked against an arithmetic reference model.
module tb_td_cpu;

`ifdef TD_CPU_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tick  = 1'b0;
    logic [3:0]  rom_addr0, user_in0 = 4'd0, user_out0;
    logic [7:0]  rom_data0 = 8'd0;
    logic        carry0, retire0, halted0;
    logic [5:0]  rom_addr1;
    logic [7:0]  user_in1 = 8'd0, user_out1;
    logic [11:0] rom_data1 = 12'd0;
    logic        carry1, retire1, halted1;

    logic [7:0]  rom0 [16];
    logic [11:0] rom1 [64];

    typedef struct {int pc; int out; int c; int h; int cyc;} exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int m_a[2], m_b[2], m_out[2], m_c[2], m_pc[2], m_halt[2], m_pend[2];
    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    td_cpu #(.DATA_W(4), .ADDR_W(4)) dut0 (
        .clock(clock), .reset(reset), .tick(tick), .rom_addr(rom_addr0), .rom_data(rom_data0),
        .user_in(user_in0), .user_out(user_out0), .carry(carry0), .retire(retire0), .halted(halted0));

    td_cpu #(.DATA_W(8), .ADDR_W(6)) dut1 (
        .clock(clock), .reset(reset), .tick(tick), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .user_in(user_in1), .user_out(user_out1), .carry(carry1), .retire(retire1), .halted(halted1));

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc       <= cyc + 1;
        rom_data0 <= rom0[rom_addr0];
        rom_data1 <= rom1[rom_addr1];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every retire pulse must match the oldest expected instruction result.
    always @(negedge clock) begin
        if (retire0) begin
            if (q0.size() == 0) chk("retire0_spurious", 1, 0);
            else begin
                e0 = q0.pop_front();
                chk("pc0", int'(rom_addr0), e0.pc);
                chk("out0", int'(user_out0), e0.out);
                chk("carry0", int'(carry0), e0.c);
                chk("halted0", int'(halted0), e0.h);
                chk("latency0", cyc, e0.cyc);
            end
        end
        if (retire1) begin
            if (q1.size() == 0) chk("retire1_spurious", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk("pc1", int'(rom_addr1), e1.pc);
                chk("out1", int'(user_out1), e1.out);
                chk("carry1", int'(carry1), e1.c);
                chk("halted1", int'(halted1), e1.h);
                chk("latency1", cyc, e1.cyc);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_a[i] = 0; m_b[i] = 0; m_out[i] = 0; m_c[i] = 0;
            m_pc[i] = 0; m_halt[i] = 0; m_pend[i] = 0;
        end
    endtask

    // Reference semantics of one instruction, applied at the clock edge that executes it.
    task automatic model_exec(input int i);
        int dw, dmask, amask, w, op, im, uin, npc, nc, s;
        exp_t item;
        dw    = (i == 0) ? 4 : 8;
        dmask = (1 << dw) - 1;
        amask = (i == 0) ? 15 : 63;
        w     = (i == 0) ? int'(rom0[m_pc[0]]) : int'(rom1[m_pc[1]]);
        uin   = (i == 0) ? int'(user_in0) : int'(user_in1);
        op    = w >> dw;
        im    = w & dmask;
        npc   = (m_pc[i] + 1) & amask;
        nc    = 0;
        case (op)
            0: begin s = m_a[i] + im; nc = (s > dmask) ? 1 : 0; m_a[i] = s & dmask; end
            1: m_a[i] = m_b[i];
            2: m_a[i] = uin;
            3: m_a[i] = im;
            4: m_b[i] = m_a[i];
            5: begin s = m_b[i] + im; nc = (s > dmask) ? 1 : 0; m_b[i] = s & dmask; end
            6: m_b[i] = uin;
            7: m_b[i] = im;
            9: m_out[i] = m_b[i];
            11: m_out[i] = im;
            12: if (HALT_EN) begin m_halt[i] = 1; npc = m_pc[i]; end
            14: if (m_c[i] == 0) npc = im & amask;
            15: npc = im & amask;
            default: ;
        endcase
        m_c[i]  = nc;
        m_pc[i] = npc;
        item = '{pc: npc, out: m_out[i], c: nc, h: m_halt[i], cyc: cyc + 1};
        if (i == 0) q0.push_back(item);
        else q1.push_back(item);
    endtask

    // Drive inputs for the coming edge and advance the model to match it.
    task automatic step(input bit t, input bit r);
        @(posedge clock);
        #1;
        tick     = t;
        reset    = r;
        user_in0 = 4'($urandom);
        user_in1 = 8'($urandom);
        if (!r) model_reset();
        else begin
            for (int i = 0; i < 2; i++) begin
                if (m_pend[i] != 0) begin
                    model_exec(i);
                    m_pend[i] = 0;
                end else if (t && m_halt[i] == 0) begin
                    m_pend[i] = 1;
                end
            end
        end
    endtask

    task automatic chk_rst();
        @(negedge clock);
        chk("rst_addr0", int'(rom_addr0), 0);  chk("rst_out0", int'(user_out0), 0);
        chk("rst_carry0", int'(carry0), 0);    chk("rst_retire0", int'(retire0), 0);
        chk("rst_halted0", int'(halted0), 0);
        chk("rst_addr1", int'(rom_addr1), 0);  chk("rst_out1", int'(user_out1), 0);
        chk("rst_carry1", int'(carry1), 0);    chk("rst_retire1", int'(retire1), 0);
        chk("rst_halted1", int'(halted1), 0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk_rst();
    endtask

    task automatic run(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            if (rnd) step($urandom_range(0, 3) != 0, $urandom_range(0, 63) != 0);
            else step(1'b1, 1'b1);
        end
    endtask

    task automatic end_check();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        @(negedge clock);
        chk("final_pc0", int'(rom_addr0), m_pc[0]);   chk("final_out0", int'(user_out0), m_out[0]);
        chk("final_carry0", int'(carry0), m_c[0]);    chk("final_halted0", int'(halted0), m_halt[0]);
        chk("missing_retire0", q0.size(), 0);
        chk("final_pc1", int'(rom_addr1), m_pc[1]);   chk("final_out1", int'(user_out1), m_out[1]);
        chk("final_carry1", int'(carry1), m_c[1]);    chk("final_halted1", int'(halted1), m_halt[1]);
        chk("missing_retire1", q1.size(), 0);
    endtask

    task automatic prog0(input logic [7:0] w0, w1, w2, w3);
        for (int k = 0; k < 16; k++) rom0[k] = 8'h80;
        rom0[0] = w0; rom0[1] = w1; rom0[2] = w2; rom0[3] = w3;
    endtask

    task automatic prog1(input logic [11:0] w0, w1, w2, w3);
        for (int k = 0; k < 64; k++) rom1[k] = 12'h800;
        rom1[0] = w0; rom1[1] = w1; rom1[2] = w2; rom1[3] = w3;
    endtask

    initial begin
        model_reset();
        prog0(8'h33, 8'h0E, 8'hE5, 8'h90);
        prog1(12'h3F0, 12'h020, 12'h400, 12'h900);
        do_reset();
        run(8, 1'b0);
        end_check();

        prog0(8'h75, 8'h90, 8'h80, 8'h80);
        prog1(12'h800, 12'h800, 12'h800, 12'h800);
        do_reset();
        run(4, 1'b0);
        end_check();

        prog0(8'h01, 8'hE0, 8'h40, 8'h90);
        do_reset();
        run(70, 1'b0);
        end_check();

        prog0(8'h80, 8'h80, 8'h80, 8'h80);
        do_reset();
        run(40, 1'b0);
        end_check();

        prog0(8'hBA, 8'hC0, 8'h80, 8'h80);
        prog1(12'hBAA, 12'hC00, 12'h800, 12'h800);
        do_reset();
        run(20, 1'b0);
        end_check();

        prog0(8'h07, 8'h40, 8'h90, 8'h80);
        prog1(12'h007, 12'h400, 12'h900, 12'h800);
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk_rst();
        prog0(8'h40, 8'h90, 8'h80, 8'h80);
        prog1(12'h400, 12'h900, 12'h800, 12'h800);
        step(1'b0, 1'b1);
        run(4, 1'b0);
        end_check();

        for (int seg = 0; seg < 10; seg++) begin
            for (int k = 0; k < 16; k++) rom0[k] = 8'($urandom);
            for (int k = 0; k < 64; k++) rom1[k] = 12'($urandom);
            do_reset();
            run(200, 1'b1);
            end_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
